// File: rtl/mux_32_8.sv
// mux_32_8: 32-to-8 serializer, MSB first, one byte per clk_4f cycle.
// A one-word pending buffer lets back-to-back words stream with no idle slot.
// Build option: define MUX_IDLE_FILL_EN to drive IDLE_BYTE on data_out while idle;
// otherwise idle slots carry 8'h00.
module mux_32_8 #(
   parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
   input  logic        clk_4f,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        in_ready,
   output logic [7:0]  data_out,
   output logic        valid_out
);

   localparam int unsigned W_WORD = 32;
   localparam int unsigned N_BYTE = 4;
   localparam int unsigned W_BYTE = 8;
   localparam int unsigned W_CNT  = 2;

`ifdef MUX_IDLE_FILL_EN
   localparam logic [W_BYTE-1:0] IDLE_VAL = IDLE_BYTE;
`else
   // Fill disabled: idle slots are zero; IDLE_BYTE stays for a uniform interface.
   localparam logic [W_BYTE-1:0] IDLE_VAL = IDLE_BYTE & 8'h00;
`endif

   typedef enum logic {IDLE, SEND} state_t;

   state_t                           state, state_nxt;
   logic [W_CNT-1:0]                 cnt, cnt_nxt;
   logic [N_BYTE-1:0][W_BYTE-1:0]    shreg, shreg_nxt;
   logic [W_WORD-1:0]                pend, pend_nxt;
   logic                             pend_valid, pend_valid_nxt;
   logic [W_BYTE-1:0]                data_out_nxt;
   logic                             valid_out_nxt;
   logic                             accept;
   logic                             pop;
   logic [W_CNT-1:0]                 byte_sel;

   // Upstream may hand over a word whenever the pending buffer is empty.
   assign in_ready = ~pend_valid;

   // Next-state, pending-buffer and output decode.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      shreg_nxt      = shreg;
      pend_nxt       = pend;
      pend_valid_nxt = pend_valid;
      data_out_nxt   = data_out;
      valid_out_nxt  = valid_out;
      pop            = 1'b0;
      accept         = valid_in & ~pend_valid;
      // Byte index 0 is the MSB, stored in shreg[3].
      byte_sel       = W_CNT'(N_BYTE - 1) - (cnt + W_CNT'(1));

      case (state)
         IDLE: begin
            if (pend_valid) begin
               pop = 1'b1;
            end else begin
               valid_out_nxt = 1'b0;
               data_out_nxt  = IDLE_VAL;
            end
         end
         SEND: begin
            if (cnt != W_CNT'(N_BYTE - 1)) begin
               data_out_nxt  = shreg[byte_sel];
               valid_out_nxt = 1'b1;
               cnt_nxt       = cnt + W_CNT'(1);
            end else if (pend_valid) begin
               pop = 1'b1;
            end else begin
               state_nxt     = IDLE;
               valid_out_nxt = 1'b0;
               data_out_nxt  = IDLE_VAL;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Pop the pending word straight onto the output: MSB goes out this edge.
      if (pop) begin
         shreg_nxt     = pend;
         data_out_nxt  = pend[W_WORD-1 -: W_BYTE];
         valid_out_nxt = 1'b1;
         cnt_nxt       = '0;
         state_nxt     = SEND;
      end

      // Accept and pop are mutually exclusive: they need opposite pend_valid.
      if (pop) begin
         pend_valid_nxt = 1'b0;
      end else if (accept) begin
         pend_valid_nxt = 1'b1;
      end

      if (accept) begin
         pend_nxt = data_in;
      end
   end

   // State and output registers; reset discards any word in flight.
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         data_out   <= IDLE_VAL;
         valid_out  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         shreg      <= shreg_nxt;
         pend       <= pend_nxt;
         pend_valid <= pend_valid_nxt;
         data_out   <= data_out_nxt;
         valid_out  <= valid_out_nxt;
      end
   end

endmodule

// File: tb/tb_mux_32_8.sv
// tb_mux_32_8: directed bench for mux_32_8 with a byte-queue reference model.
`timescale 1ns/1ps
module tb_mux_32_8;

`ifdef MUX_IDLE_FILL_EN
   localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
   localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

   logic        clk_4f   = 1'b0;
   logic        reset    = 1'b0;
   logic [31:0] data_in  = '0;
   logic        valid_in = 1'b0;
   logic        in_ready;
   logic [7:0]  data_out;
   logic        valid_out;

   mux_32_8 #(.IDLE_BYTE(8'hBC)) dut (
      .clk_4f   (clk_4f),
      .reset    (reset),
      .data_in  (data_in),
      .valid_in (valid_in),
      .in_ready (in_ready),
      .data_out (data_out),
      .valid_out(valid_out)
   );

   always #5 clk_4f = ~clk_4f;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: pending slot plus a queue of bytes still to be shown.
   bit          m_pv;
   logic [31:0] m_pend;
   logic [7:0]  m_q[$];
   logic [7:0]  m_dout;
   logic        m_vout;

   initial begin
      bit acc;
      m_pv = 0; m_pend = '0; m_dout = IDLE_EXP; m_vout = 0;
      forever begin
         @(posedge clk_4f or posedge reset);
         if (reset) begin
            m_pv = 0; m_pend = '0; m_q.delete(); m_dout = IDLE_EXP; m_vout = 0;
         end else begin
            acc = valid_in && !m_pv;
            if (m_q.size() == 0) begin
               if (m_pv) begin
                  m_dout = m_pend[31:24];
                  m_vout = 1;
                  m_q.push_back(m_pend[23:16]);
                  m_q.push_back(m_pend[15:8]);
                  m_q.push_back(m_pend[7:0]);
                  m_pv = 0;
               end else begin
                  m_dout = IDLE_EXP;
                  m_vout = 0;
               end
            end else begin
               m_dout = m_q.pop_front();
               m_vout = 1;
            end
            if (acc) begin
               m_pend = data_in;
               m_pv   = 1;
            end
         end
      end
   end

   // Per-cycle compare against the model, plus a log of emitted bytes.
   bit         run = 0;
   int         cyc = 0;
   logic [7:0] log_b[$];
   int         log_cyc[$];

   initial begin
      forever begin
         @(negedge clk_4f);
         cyc++;
         if (run) begin
            chk("cycle_out", 64'({in_ready, valid_out, data_out}),
                64'({!m_pv, m_vout, m_dout}));
            if (valid_out) begin
               log_b.push_back(data_out);
               log_cyc.push_back(cyc);
            end
         end
      end
   end

   function automatic logic [63:0] pack_log();
      logic [63:0] r = '0;
      foreach (log_b[i]) r = {r[55:0], log_b[i]};
      return r;
   endfunction

   function automatic logic [31:0] log_word(input int k);
      if (log_b.size() < 4*k + 4) return 32'h0;
      return {log_b[4*k], log_b[4*k+1], log_b[4*k+2], log_b[4*k+3]};
   endfunction

   task automatic clear_log();
      log_b.delete();
      log_cyc.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_4f);
      #1;
   endtask

   // Present a word and hold it until an edge sees in_ready high.
   task automatic send_word(input logic [31:0] w);
      bit rdy;
      int n;
      n = 0;
      valid_in = 1'b1;
      data_in  = w;
      do begin
         rdy = in_ready;
         @(posedge clk_4f);
         #1;
         n++;
      end while (!rdy && n < 50);
      chk("send_accept", 64'(rdy), 64'd1);
      valid_in = 1'b0;
   endtask

   logic [31:0] sent[$];
   logic [31:0] bp_exp[4];
   int          acc_cyc;
   logic [7:0]  k;
   bit          rdy;

   initial begin
      bp_exp[0] = 32'hA0B0C0D0;
      bp_exp[1] = 32'hA2B2C2D2;
      bp_exp[2] = 32'hA6B6C6D6;
      bp_exp[3] = 32'hAABACADA;

      #1 reset = 1'b1;
      #1 run = 1;
      chk("reset_state", 64'({in_ready, valid_out, data_out}), 64'({1'b1, 1'b0, IDLE_EXP}));
      repeat (2) @(posedge clk_4f);
      #1 reset = 1'b0;

      // Single word, with latency from accept edge to MSB.
      clear_log();
      send_word(32'hEEFFFDCC);
      acc_cyc = cyc;
      wait_cycles(7);
      chk("single_len", 64'(log_b.size()), 64'd4);
      chk("single_bytes", pack_log(), 64'h00000000_EEFFFDCC);
      if (log_cyc.size() > 0) chk("single_latency", 64'(log_cyc[0] - acc_cyc), 64'd2);
      chk("single_idle", 64'({valid_out, data_out}), 64'({1'b0, IDLE_EXP}));

      // Back-to-back words stream with no idle slot.
      clear_log();
      send_word(32'hEEFFFDCC);
      send_word(32'hAA12BB00);
      wait_cycles(10);
      chk("b2b_len", 64'(log_b.size()), 64'd8);
      chk("b2b_bytes", pack_log(), 64'hEEFFFDCC_AA12BB00);
      if (log_cyc.size() == 8) chk("b2b_contig", 64'(log_cyc[7] - log_cyc[0]), 64'd7);

      // Backpressure: data_in changes every cycle, only accepted words appear.
      clear_log();
      sent.delete();
      for (int i = 0; i < 12; i++) begin
         k = 8'(i);
         data_in  = {8'hA0 + k, 8'hB0 + k, 8'hC0 + k, 8'hD0 + k};
         valid_in = 1'b1;
         rdy = in_ready;
         @(posedge clk_4f);
         #1;
         if (rdy) sent.push_back(data_in);
      end
      valid_in = 1'b0;
      wait_cycles(20);
      chk("bp_accepts", 64'(sent.size()), 64'd4);
      chk("bp_len", 64'(log_b.size()), 64'd16);
      for (int w = 0; w < 4; w++) begin
         chk("bp_word", 64'(log_word(w)), 64'(bp_exp[w]));
         if (w < sent.size()) chk("bp_loopback", 64'(log_word(w)), 64'(sent[w]));
      end

      // Reset while the second byte is on the output.
      clear_log();
      send_word(32'h11223344);
      for (int n = 0; n < 20 && log_b.size() < 2; n++) begin
         @(negedge clk_4f);
         #1;
      end
      chk("mid_seen2", 64'(log_b.size()), 64'd2);
      #1 reset = 1'b1;
      #1;
      chk("mid_reset_out", 64'({in_ready, valid_out, data_out}), 64'({1'b1, 1'b0, IDLE_EXP}));
      @(posedge clk_4f);
      #1 reset = 1'b0;
      wait_cycles(8);
      chk("mid_bytes", pack_log(), 64'h1122);
      chk("mid_len", 64'(log_b.size()), 64'd2);

      // Idle gap between two words; reassemble as a downstream demux would.
      clear_log();
      send_word(32'h01020304);
      wait_cycles(6);
      send_word(32'h05060708);
      wait_cycles(8);
      chk("gap_len", 64'(log_b.size()), 64'd8);
      chk("gap_bytes", pack_log(), 64'h01020304_05060708);
      if (log_cyc.size() == 8) chk("gap_present", 64'(log_cyc[4] - log_cyc[3] > 1), 64'd1);
      chk("gap_word0", 64'(log_word(0)), 64'h01020304);
      chk("gap_word1", 64'(log_word(1)), 64'h05060708);

      run = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mux_32_8.md
# mux_32_8

Single-clock 32-to-8 serializer: the transmit-side counterpart of `demux_8_32` in the PCI physical-layer datapath. It accepts 32-bit words over a valid/ready handshake and emits them one byte per `clk_4f` cycle, most-significant byte first. This byte order is the one `demux_8_32` reassembles. A one-word pending buffer allows back-to-back words to stream with no idle byte slots.

## Interface
Parameters:
- `IDLE_BYTE`, default 8'hBC: byte driven on `data_out` during idle slots; used only when `MUX_IDLE_FILL_EN` is defined.

Ports:
- `clk_4f`  input  1  byte-rate clock; every register updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset; clears all state immediately.
- `data_in`  input  32  word to serialize; sampled when `valid_in && in_ready` at a rising edge.
- `valid_in`  input  1  `data_in` holds a word.
- `in_ready`  output  1  pending buffer is empty and can accept a word.
- `data_out`  output  8  registered serialized byte.
- `valid_out`  output  1  registered; `data_out` carries a payload byte.

## Operation
- Internal state:
  - `pend` (32 b) and `pend_valid`.
  - `shreg` (32 b).
  - `cnt` (2 b).
  - FSM with states IDLE and SEND.
- `in_ready = ~pend_valid`. This is combinational from a register and has no dependency on `valid_in`.
- Accept: on an edge with `valid_in && in_ready`, set `pend <= data_in` and `pend_valid <= 1`.
- IDLE:
  - If `pend_valid`: load `shreg <= pend` and set `data_out <= pend[31:24]`, `valid_out <= 1`, `cnt <= 0`, clear `pend_valid`, go to SEND.
  - Otherwise: `valid_out <= 0` and `data_out` takes its idle value.
- SEND, `cnt` 0..2: at each edge, emit the next byte and increment `cnt`. The byte sequence is `shreg[23:16]`, then `[15:8]`, then `[7:0]`.
- SEND, `cnt == 3` (last byte is currently on the output):
  - If `pend_valid`: reload from `pend` exactly as in IDLE and stay in SEND. There is no gap.
  - Otherwise: go to IDLE with `valid_out <= 0`.
- Same-edge accept and pop: cannot occur. Accept requires `pend_valid == 0`; pop requires `pend_valid == 1`.
- `data_in` is ignored when `valid_in` is low or `in_ready` is low. The upstream block must hold the word until it is accepted.
- Reset (asynchronous, at any time, including mid-word):
  - FSM goes to IDLE; `cnt`, `pend_valid`, `shreg` and `pend` are cleared.
  - `valid_out` = 0.
  - `data_out` = idle value.
  - `in_ready` = 1.
  - Partially sent words are discarded. No byte of a discarded word appears after reset.

## Timing
- Latency:
  - Word accepted at edge N; its MSB appears on `data_out` after edge N+1.
  - Bytes follow after edges N+2, N+3 and N+4.
- Throughput: one word per 4 cycles, sustained with `valid_out` held continuously high. The pending word is reloaded at the `cnt == 3` edge, and `in_ready` rises in the following cycle.
- Once `pend` is filled, `in_ready` stays low until the FSM pops the word. The pop happens on the next IDLE edge or on the next `cnt == 3` edge.
- After reset deassertion, the first accept can happen at the first rising edge.

## Configuration
- `MUX_IDLE_FILL_EN`:
  - Defined: in IDLE and at reset, `data_out` = `IDLE_BYTE` and `valid_out` = 0. This provides a link fill symbol.
  - Undefined: in IDLE and at reset, `data_out` = 8'h00. `IDLE_BYTE` is unused.
- Payload timing and the handshake are identical in both builds.

## Test plan
- Single word: reset, then present 32'hEEFFFDCC for one cycle with `in_ready` high.
  - `data_out` = EE, FF, FD, CC on 4 consecutive cycles with `valid_out` = 1.
  - Then `valid_out` = 0 and `data_out` = 8'h00 (or 8'hBC with the macro defined).
- Back-to-back: present 32'hEEFFFDCC then 32'hAA12BB00, `valid_in` held high.
  - Output is 8 contiguous valid bytes: EE FF FD CC AA 12 BB 00.
  - `in_ready` is low for exactly the cycles while `pend` is full.
- Backpressure: hold `valid_in` high with changing `data_in` while `in_ready` is low.
  - Only the words sampled at accept edges are emitted; no word is duplicated or dropped.
- Reset mid-word: send 32'h11223344 and assert `reset` after byte 22.
  - Immediately: `valid_out` = 0, `in_ready` = 1, `data_out` = idle value.
  - Bytes 33 and 44 are never emitted.
- Idle gap: send 32'h01020304, wait 6 cycles, then send 32'h05060708.
  - Exactly 8 valid bytes in order, with `valid_out` low during the gap.
- Loopback: connect the output to `demux_8_32` (byte `data_in`/`valid`).
  - The reassembled 32-bit words equal the words sent, in both macro builds.
